if_fetch: RTL
=============

IF_FETCH -- requirements
Module: if_fetch

Interface
REQ-001 Parameter XLEN, default 32, address and instruction width.
REQ-002 Parameter BOOT_PC, default 32'h0000_0200, first fetch address after reset.
REQ-003 Parameter DEPTH, default 4, instruction FIFO entries (power of two, >=2).
REQ-004 clk_i  in  1  sole clock, rising edge.
REQ-005 rst_n_i  in  1  reset, asynchronous, active-low.
REQ-006 flush_i  in  1  redirect request from the execute stage.
REQ-007 flush_pc_i  in  XLEN  redirect target, sampled when flush_i=1.
REQ-008 flush_o  out  1  flush forwarded to the cache-interface stage.
REQ-009 pc_o  out  XLEN  fetch address, meaningful when read_req_o=1.
REQ-010 read_req_o  out  1  single-cycle fetch request pulse to the cache-interface stage.
REQ-011 instr_i  in  XLEN  returned instruction word, valid when read_done_i=1.
REQ-012 read_done_i  in  1  fetch completion pulse.
REQ-013 instr_o  out  XLEN  FIFO head instruction to decode.
REQ-014 instr_pc_o  out  XLEN  PC of FIFO head.
REQ-015 instr_valid_o  out  1  FIFO non-empty.
REQ-016 instr_ready_i  in  1  decode accepts head; transfer when instr_valid_o & instr_ready_i.

Function
REQ-017 The FSM SHALL have states RESET, IDLE (no request outstanding), WAIT (one request outstanding).
REQ-018 At most one fetch SHALL be outstanding at any time.
REQ-019 pc register SHALL hold the next address to fetch; pc_o = pc register, combinational.
REQ-020 A request SHALL issue only if occ_next + 0 < DEPTH, where occ_next = count + push - pop for the current cycle.
REQ-021 RESET: read_req_o=0; next state IDLE unconditionally.
REQ-022 IDLE: if credit available, read_req_o=1, next WAIT; else read_req_o=0, stay IDLE.
REQ-023 WAIT without read_done_i: read_req_o=0, stay WAIT.
REQ-024 WAIT with read_done_i: push {instr_i, req_pc}; if credit available, read_req_o=1 in the same cycle and stay WAIT (back-to-back); else go to IDLE.
REQ-025 On each issue: req_pc <= pc; pc <= pc + 4, wrapping modulo 2^XLEN (32'hFFFF_FFFC -> 0).
REQ-026 read_done_i in IDLE or RESET SHALL be ignored (no push).
REQ-027 FIFO SHALL be circular, wrap-around pointers, simultaneous push and pop allowed; count unchanged.
REQ-028 Push when full SHALL be impossible by REQ-020; pop when empty SHALL be a no-op.
REQ-029 flush_o SHALL equal flush_i combinationally.
REQ-030 flush_i=1: read_req_o=0 that cycle; FIFO cleared, pc <= flush_pc_i, next state IDLE; overrides every other event.
REQ-031 read_done_i coincident with flush_i SHALL be discarded; pop coincident with flush_i still counts as a transfer to decode.
REQ-032 First request after flush SHALL issue the cycle after flush, pc_o = flush_pc_i.
REQ-033 Instruction order at instr_o SHALL match request order; FIFO is not bypassed (push-to-valid latency 1 cycle).

Reset
REQ-034 rst_n_i low SHALL immediately force: state RESET, pc = BOOT_PC, req_pc = 0, FIFO empty, pointers 0.
REQ-035 During and right after reset: read_req_o=0, instr_valid_o=0, instr_o=0, instr_pc_o=0, pc_o=BOOT_PC.
REQ-036 Reset mid-transaction SHALL abandon the outstanding fetch; a later read_done_i before a new request is ignored.

Verification
REQ-037 Reset release, done returned 2 cycles after each req, ready=1 -> first req 1 cycle after RESET at pc 0x200, then 0x204, 0x208; decode sees same order.
REQ-038 instr_ready_i=0, done immediate -> exactly 4 fetches (0x200..0x20C), instr_valid_o stays 1, no 5th req; one pop -> one new req at 0x210.
REQ-039 flush_i with flush_pc_i=0x1000 coincident with read_done_i -> that word dropped, FIFO empty next cycle, next req at 0x1000.
REQ-040 pc=32'hFFFF_FFFC issued -> next pc_o = 0x0000_0000.
REQ-041 rst_n_i low while WAIT, then read_done_i pulse after release -> no push, first req at 0x200.
REQ-042 Simultaneous push and pop at count=2 -> count stays 2, data order preserved.

Source files
------------

// File: rtl/if_fetch.sv
// Instruction fetch stage.
//
// Issues one fetch at a time to the cache-interface stage, buffers returned
// instruction words together with their PCs in a small circular FIFO, and
// presents the FIFO head to decode. An execute-stage redirect (flush) clears
// the FIFO, drops any in-flight return and restarts fetching at the target.
//
// Ports:
//   clk_i          sole clock, rising edge
//   rst_n_i        asynchronous active-low reset
//   flush_i        redirect request from execute
//   flush_pc_i     redirect target, sampled when flush_i=1
//   flush_o        flush forwarded to the cache-interface stage
//   pc_o           fetch address, meaningful when read_req_o=1
//   read_req_o     single-cycle fetch request pulse
//   instr_i        returned instruction word, valid with read_done_i
//   read_done_i    fetch completion pulse
//   instr_o        FIFO head instruction
//   instr_pc_o     PC of FIFO head
//   instr_valid_o  FIFO non-empty
//   instr_ready_i  decode accepts the head
module if_fetch #(
   parameter int unsigned     XLEN    = 32,
   parameter logic [XLEN-1:0] BOOT_PC = 32'h0000_0200,
   parameter int unsigned     DEPTH   = 4
) (
   input  logic            clk_i,
   input  logic            rst_n_i,
   input  logic            flush_i,
   input  logic [XLEN-1:0] flush_pc_i,
   output logic            flush_o,
   output logic [XLEN-1:0] pc_o,
   output logic            read_req_o,
   input  logic [XLEN-1:0] instr_i,
   input  logic            read_done_i,
   output logic [XLEN-1:0] instr_o,
   output logic [XLEN-1:0] instr_pc_o,
   output logic            instr_valid_o,
   input  logic            instr_ready_i
);

   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned CNT_W = PTR_W + 1;

   typedef enum logic [1:0] {StReset, StIdle, StWait} state_e;

   state_e            state_q, state_d;
   logic [XLEN-1:0]   pc_q;
   logic [XLEN-1:0]   req_pc_q;
   logic [XLEN-1:0]   mem_instr [DEPTH];
   logic [XLEN-1:0]   mem_pc    [DEPTH];
   logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
   logic [CNT_W-1:0]  count_q;
   logic [CNT_W-1:0]  occ_next;
   logic              push, pop, credit, issue;

   // A return is only accepted while a fetch is outstanding and not flushed.
   assign push     = (state_q == StWait) & read_done_i & ~flush_i;
   assign pop      = instr_valid_o & instr_ready_i;
   assign occ_next = count_q + CNT_W'(push) - CNT_W'(pop);
   // Reserve a slot for the word this request will return.
   assign credit   = occ_next < CNT_W'(DEPTH);

   assign flush_o       = flush_i;
   assign pc_o          = pc_q;
   assign read_req_o    = issue;
   assign instr_valid_o = (count_q != '0);
   assign instr_o       = instr_valid_o ? mem_instr[rd_ptr_q] : '0;
   assign instr_pc_o    = instr_valid_o ? mem_pc[rd_ptr_q]    : '0;

   // State register.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state_q <= StReset;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic.
   always_comb begin
      state_d = state_q;
      if (flush_i) begin
         state_d = StIdle;
      end else begin
         unique case (state_q)
            StReset: state_d = StIdle;
            StIdle:  if (credit) state_d = StWait;
            StWait:  if (read_done_i && !credit) state_d = StIdle;
            default: state_d = StReset;
         endcase
      end
   end

   // Output logic: request pulse.
   always_comb begin
      issue = 1'b0;
      if (!flush_i) begin
         case (state_q)
            StIdle:  issue = credit;
            StWait:  issue = read_done_i & credit;
            default: issue = 1'b0;
         endcase
      end
   end

   // PC and FIFO control.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         pc_q     <= BOOT_PC;
         req_pc_q <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else if (flush_i) begin
         pc_q     <= flush_pc_i;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (issue) begin
            req_pc_q <= pc_q;
            pc_q     <= pc_q + XLEN'(4);
         end
         if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
         if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
         count_q <= occ_next;
      end
   end

   // FIFO storage; contents are only observed through the count-gated outputs.
   always_ff @(posedge clk_i) begin
      if (push) begin
         mem_instr[wr_ptr_q] <= instr_i;
         mem_pc[wr_ptr_q]    <= req_pc_q;
      end
   end

endmodule
